mapper_arbiter: RTL and testbench

MAPPER_ARBITER -- requirements
Module: mapper_arbiter

---
 rtl/mapper_arbiter_pkg.sv | 14 +
 rtl/mapper_arbiter_rr_pick.sv | 34 +++
 rtl/mapper_arbiter.sv | 125 ++++++++++++
 tb/tb_mapper_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mapper_arbiter_pkg.sv
// Shared definitions for the mapper arbiter: parameter defaults and FSM states.
package mapper_arbiter_pkg;

  localparam int DATA_W_DEF    = 64;
  localparam int MAX_BURST_DEF = 4;
  // Burst counter width; wide enough for the largest allowed burst (15).
  localparam int BURST_W       = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/mapper_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or above start, wrapping.
module rr_pick
  import mapper_arbiter_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]         req,
  input  logic [$clog2(NUM_LANES)-1:0] start,
  output logic [NUM_LANES-1:0]         grant,
  output logic [$clog2(NUM_LANES)-1:0] idx,
  output logic                         any
);

  localparam int LW = $clog2(NUM_LANES);

  logic [LW-1:0] cand;

  // Scan lanes start, start+1, ... (modulo NUM_LANES) and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = start + LW'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mapper_arbiter.sv
// Burst-locking round-robin arbiter merging NUM_LANES mapper lanes into one
// registered output stage.
module mapper_arbiter
  import mapper_arbiter_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           io_rx_val,
  output logic [NUM_LANES-1:0]           io_rx_rdy,
  input  logic [NUM_LANES*DATA_W-1:0]    io_rx_dat,
  output logic                           io_tx_val,
  input  logic                           io_tx_rdy,
  output logic [DATA_W-1:0]              io_tx_dat,
  output logic [$clog2(NUM_LANES)-1:0]   io_tx_src
);

  localparam int LW = $clog2(NUM_LANES);

  state_t               state, state_nxt;
  logic [LW-1:0]        lock_lane, lock_nxt;
  logic [LW-1:0]        rr_ptr, rr_nxt;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt;

  logic                 load_en;
  logic                 lock_hold;
  logic [LW-1:0]        pick_start;
  logic [NUM_LANES-1:0] pick_grant;
  logic [LW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 sel_any;
  logic [LW-1:0]        sel;
  logic [NUM_LANES-1:0] grant_vec;
  logic [DATA_W-1:0]    sel_dat_p0;

  logic                 vld_p1;
  logic [DATA_W-1:0]    dat_p1;
  logic [LW-1:0]        src_p1;

  // On release the search restarts just past the lock lane, so the
  // lock lane itself is considered last and only wins if nobody else is valid.
  rr_pick #(.NUM_LANES(NUM_LANES)) u_pick (
    .req   (io_rx_val),
    .start (pick_start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Lane selection and per-lane ready; ready is gated by output-stage space.
  always_comb begin
    load_en    = !vld_p1 || io_tx_rdy;
    lock_hold  = (state == LOCKED) && io_rx_val[lock_lane] &&
                 (burst_cnt < BURST_W'(MAX_BURST));
    pick_start = (state == LOCKED) ? lock_lane + LW'(1) : rr_ptr;
    sel_any    = lock_hold || pick_any;
    sel        = lock_hold ? lock_lane : pick_idx;
    grant_vec  = pick_grant;
    if (lock_hold) begin
      grant_vec            = '0;
      grant_vec[lock_lane] = 1'b1;
    end
    io_rx_rdy  = (load_en && !reset) ? grant_vec : '0;
    sel_dat_p0 = io_rx_dat[sel*DATA_W +: DATA_W];
  end

  // Next-state logic: lock/burst/pointer only move when the output stage loads.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_lane;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    if (load_en) begin
      if (state == LOCKED && !lock_hold) rr_nxt = lock_lane + LW'(1);
      if (lock_hold) begin
        burst_nxt = burst_cnt + BURST_W'(1);
      end else if (pick_any) begin
        state_nxt = LOCKED;
        lock_nxt  = pick_idx;
        burst_nxt = BURST_W'(1);
      end else begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_lane <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      lock_lane <= lock_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // p0 -> p1: output register; word and source hold while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
      src_p1 <= '0;
    end else if (load_en) begin
      vld_p1 <= sel_any;
      if (sel_any) begin
        dat_p1 <= sel_dat_p0;
        src_p1 <= sel;
      end
    end
  end

  assign io_tx_val = vld_p1;
  assign io_tx_dat = dat_p1;
  assign io_tx_src = src_p1;

endmodule

// File: tb/tb_mapper_arbiter.sv
// Self-checking bench for mapper_arbiter: directed scenarios plus random
// val/rdy traffic against a behavioural arbitration model.
module tb_mapper_arbiter;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NL-1:0]    rx_val = '0;
  logic [NL-1:0]    rx_rdy;
  logic [NL*DW-1:0] rx_dat = '0;
  logic             tx_val;
  logic             tx_rdy = 1'b0;
  logic [DW-1:0]    tx_dat;
  logic [1:0]       tx_src;

  mapper_arbiter #(.NUM_LANES(NL), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_rx_val (rx_val),
    .io_rx_rdy (rx_rdy),
    .io_rx_dat (rx_dat),
    .io_tx_val (tx_val),
    .io_tx_rdy (tx_rdy),
    .io_tx_dat (tx_dat),
    .io_tx_src (tx_src)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: who owns the output, how many beats it has had,
  // where the next search begins, and what the output register holds.
  bit          m_locked = 0;
  int          m_lock = 0;
  int          m_burst = 0;
  int          m_ptr = 0;
  bit          m_val = 0;
  logic [63:0] m_dat = '0;
  int          m_src = 0;
  int          seq[NL];
  int          wait_cnt[NL];
  int          wait_max = 0;

  // Each lane emits an increasing sequence tagged with its lane number,
  // so order and origin of every word are self-evident.
  function automatic logic [63:0] word(input int lane, input int s);
    return {8'(lane), 56'(s)};
  endfunction

  task automatic cycle(input logic [NL-1:0] v, input bit rdy, input bit rst);
    bit            any;
    bit            cont;
    bit            load;
    int            sel;
    int            start;
    logic [NL-1:0] exp_rdy;
    @(negedge clk);
    reset  = rst;
    tx_rdy = rdy;
    rx_val = v;
    for (int i = 0; i < NL; i++) rx_dat[i*DW +: DW] = word(i, seq[i]);
    any  = 0;
    cont = 0;
    sel  = 0;
    if (m_locked && v[m_lock] && m_burst < MB) begin
      any  = 1;
      cont = 1;
      sel  = m_lock;
    end else begin
      start = m_locked ? (m_lock + 1) % NL : m_ptr;
      for (int k = 0; k < NL; k++)
        if (!any && v[(start + k) % NL]) begin
          any = 1;
          sel = (start + k) % NL;
        end
    end
    load    = !m_val || rdy;
    exp_rdy = '0;
    if (any && load && !rst) exp_rdy[sel] = 1'b1;
    #1;
    chk("rx_rdy", 64'(rx_rdy), 64'(exp_rdy));
    @(posedge clk);
    for (int i = 0; i < NL; i++) begin
      if (exp_rdy[i] || !v[i] || rst) wait_cnt[i] = 0;
      else if (exp_rdy != '0) wait_cnt[i]++;
      if (wait_cnt[i] > wait_max) wait_max = wait_cnt[i];
    end
    if (rst) begin
      m_locked = 0; m_lock = 0; m_burst = 0; m_ptr = 0;
      m_val = 0; m_dat = '0; m_src = 0;
    end else if (load) begin
      if (m_locked && !cont) m_ptr = (m_lock + 1) % NL;
      if (any) begin
        if (cont) m_burst++;
        else begin
          m_locked = 1; m_lock = sel; m_burst = 1;
        end
        m_val = 1;
        m_dat = word(sel, seq[sel]);
        m_src = sel;
        seq[sel]++;
      end else begin
        m_locked = 0; m_burst = 0; m_val = 0;
      end
    end
    #1;
    chk("tx_val", 64'(tx_val), 64'(m_val));
    chk("tx_dat", tx_dat, m_dat);
    chk("tx_src", 64'(tx_src), 64'(m_src));
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      seq[i] = 0;
      wait_cnt[i] = 0;
    end

    // Reset state
    cycle('0, 1'b1, 1'b1);
    cycle('0, 1'b1, 1'b1);
    chk("reset_val", 64'(tx_val), 64'd0);
    chk("reset_dat", tx_dat, 64'd0);

    // All lanes valid, downstream always ready: bursts of four in lane order
    for (int t = 0; t < 20; t++) begin
      cycle('1, 1'b1, 1'b0);
      chk("seq_all", 64'(tx_src), 64'((t / 4) % 4));
    end

    // Only lane 2 valid: continuous output, bursts restart without bubbles
    cycle('0, 1'b1, 1'b1);
    for (int t = 0; t < 10; t++) begin
      cycle(4'b0100, 1'b1, 1'b0);
      chk("lane2_val", 64'(tx_val), 64'd1);
      chk("lane2_src", 64'(tx_src), 64'd2);
    end

    // Lane 1 locked then drops; lane 3 takes over in the next cycle
    cycle('0, 1'b1, 1'b1);
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0);
    chk("drop_src", 64'(tx_src), 64'd3);
    chk("drop_val", 64'(tx_val), 64'd1);

    // Downstream stall for five cycles, then drain
    cycle('1, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) cycle('1, 1'b0, 1'b0);
    chk("stall_val", 64'(tx_val), 64'd1);
    for (int t = 0; t < 6; t++) cycle('1, 1'b1, 1'b0);

    // Reset mid-burst with a word in the output register
    cycle('1, 1'b1, 1'b0);
    cycle('1, 1'b0, 1'b1);
    chk("rst_txval", 64'(tx_val), 64'd0);
    chk("rst_rdy", 64'(rx_rdy), 64'd0);
    cycle('1, 1'b1, 1'b0);
    chk("after_rst_src", 64'(tx_src), 64'd0);

    // Random traffic
    wait_max = 0;
    for (int i = 0; i < NL; i++) wait_cnt[i] = 0;
    for (int t = 0; t < 10000; t++)
      cycle(NL'($urandom), ($urandom % 4) != 0, 1'b0);
    chk("fairness", 64'(wait_max <= (NL - 1) * MB), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
